csr_unit: RTL

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// -----------------------------------------------------------------------------
// csr_unit
//
// Purpose:
//   Zicsr-style CSR execution unit. It holds the free-running cycle counter
//   (with time as an alias), the retired-instruction counter and a bank of
//   read/write scratch CSRs. It executes CSRRW/RS/RC and their immediate forms
//   and returns one registered response per request.
//
// Handshake:
//   There is no ready signal. A request is accepted on every rising edge where
//   req_valid=1. rsp_valid and its payload (rdata, rd_we, illegal) are
//   registered on that same edge, so they are valid for exactly the following
//   cycle. In a cycle that follows req_valid=0 the whole payload is 0.
//
// Ports:
//   clk        in   single clock, rising edge
//   nreset     in   asynchronous active-low reset
//   req_valid  in   CSR instruction presented this cycle
//   funct3     in   [2:0] CSR operation encoding
//   csr_addr   in   [11:0] CSR address
//   rs1        in   [4:0] source index / zimm for the immediate forms
//   rd         in   [4:0] destination index
//   wdata      in   [XLEN-1:0] rs1 register value
//   retire     in   one pulse per retired instruction
//   rsp_valid  out  response valid
//   rdata      out  [XLEN-1:0] old CSR value (0 on illegal)
//   rd_we      out  write rdata to rd
//   illegal    out  illegal CSR access
// -----------------------------------------------------------------------------
module csr_unit #(
    parameter int XLEN        = 32,
    parameter int NUM_SCRATCH = 4
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] wdata,
    input  logic            retire,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rdata,
    output logic            rd_we,
    output logic            illegal
);

    localparam int CW = 2 * XLEN;

    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_TIME     = 12'hC01;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_TIMEH    = 12'hC81;
    localparam logic [11:0] A_INSTRETH = 12'hC82;
    localparam logic [11:0] A_SCRATCH  = 12'h7C0;

    // Architectural state
    logic [CW-1:0]   r_cycle;
    logic [CW-1:0]   r_instret;
    logic [XLEN-1:0] r_scratch [NUM_SCRATCH];

    // Registered response
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rdata;
    logic            r_rd_we;
    logic            r_illegal;

    // Decode
    logic                   w_is_rw;
    logic                   w_op_legal;
    logic                   w_wr_intent;
    logic                   w_cnt_hit;
    logic                   w_scr_hit;
    logic [NUM_SCRATCH-1:0] w_scr_sel;
    logic                   w_illegal;
    logic                   w_rd_we;
    logic                   w_scr_write;
    logic [XLEN-1:0]        w_operand;
    logic [XLEN-1:0]        w_old;
    logic [XLEN-1:0]        w_new;

    always_comb begin
        w_is_rw     = (funct3[1:0] == 2'b01);
        w_op_legal  = (funct3[1:0] != 2'b00);
        w_operand   = funct3[2] ? {{(XLEN-5){1'b0}}, rs1} : wdata;
        // Set/clear with rs1==0 is a pure read and never counts as a write.
        w_wr_intent = w_is_rw || (rs1 != 5'd0);

        w_cnt_hit = 1'b1;
        w_old     = '0;
        case (csr_addr)
            A_CYCLE, A_TIME:   w_old = r_cycle[XLEN-1:0];
            A_INSTRET:         w_old = r_instret[XLEN-1:0];
            A_CYCLEH, A_TIMEH: w_old = r_cycle[CW-1:XLEN];
            A_INSTRETH:        w_old = r_instret[CW-1:XLEN];
            default:           w_cnt_hit = 1'b0;
        endcase

        // Loop-based select keeps the scratch bank free of index-width issues
        // for any NUM_SCRATCH in 1..16.
        w_scr_sel = '0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (csr_addr == A_SCRATCH + 12'(i)) begin
                w_scr_sel[i] = 1'b1;
                w_old        = r_scratch[i];
            end
        end
        w_scr_hit = |w_scr_sel;

        // Counters are read-only: only a suppressed write may touch them.
        w_illegal = !w_op_legal || !(w_cnt_hit || w_scr_hit) ||
                    (w_wr_intent && w_cnt_hit);

        case (funct3[1:0])
            2'b01:   w_new = w_operand;
            2'b10:   w_new = w_old | w_operand;
            2'b11:   w_new = w_old & ~w_operand;
            default: w_new = w_old;
        endcase

        w_scr_write = req_valid && !w_illegal && w_wr_intent && w_scr_hit;
        w_rd_we     = !w_illegal && !(w_is_rw && (rd == 5'd0));
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cycle     <= '0;
            r_instret   <= '0;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_rd_we     <= 1'b0;
            r_illegal   <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                r_scratch[i] <= '0;
            end
        end else begin
            // Both counters wrap silently at 2^CW.
            r_cycle <= r_cycle + CW'(1);
            if (retire) begin
                r_instret <= r_instret + CW'(1);
            end

            r_rsp_valid <= req_valid;
            r_illegal   <= req_valid && w_illegal;
            r_rd_we     <= req_valid && w_rd_we;
            r_rdata     <= (req_valid && !w_illegal) ? w_old : '0;

            // Committed on the response edge so a back-to-back access sees it.
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_scr_write && w_scr_sel[i]) begin
                    r_scratch[i] <= w_new;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rdata     = r_rdata;
    assign rd_we     = r_rd_we;
    assign illegal   = r_illegal;

endmodule
